// File: rtl/rs_pkg.sv
// Shared types for the integer reservation station: entry layout, default widths
// and the CDB snoop helper used by both dispatch bypass and wakeup.
package rs_pkg;

   localparam int RS_TAG_W  = 6;
   localparam int RS_DATA_W = 32;
   localparam int RS_OP_W   = 5;

   typedef struct packed {
      logic                 rdy;
      logic [RS_TAG_W-1:0]  tag;
      logic [RS_DATA_W-1:0] val;
   } rs_src_t;

   typedef struct packed {
      logic                valid;
      logic [RS_OP_W-1:0]  op;
      logic [RS_TAG_W-1:0] dest;
      rs_src_t             src1;
      rs_src_t             src2;
   } rs_entry_t;

   // A waiting operand whose producer tag is on the CDB becomes ready with that value.
   function automatic rs_src_t snoop(input rs_src_t s, input logic cdb_valid,
                                     input logic [RS_TAG_W-1:0] cdb_tag,
                                     input logic [RS_DATA_W-1:0] cdb_val);
      rs_src_t r;
      r = s;
      if (!s.rdy && cdb_valid && (s.tag == cdb_tag)) begin
         r.rdy = 1'b1;
         r.val = cdb_val;
      end
      return r;
   endfunction

endpackage

// File: rtl/rs_select.sv
// Issue selector: one-hot grant over the ready vector. With RS_INT_AGE_SELECT_EN
// the oldest ready entry wins (age[i][j]=1 means i is older than j), else lowest index.
module rs_select #(
   parameter int ENTRIES = 4
) (
   input  logic [ENTRIES-1:0]              ready,
`ifdef RS_INT_AGE_SELECT_EN
   input  logic [ENTRIES-1:0][ENTRIES-1:0] age,
`endif
   output logic [ENTRIES-1:0]              grant,
   output logic                            grant_valid
);

`ifdef RS_INT_AGE_SELECT_EN
   always_comb begin
      grant = '0;
      for (int i = 0; i < ENTRIES; i++) begin
         logic blocked;
         blocked = 1'b0;
         for (int j = 0; j < ENTRIES; j++) begin
            if (ready[j] && age[j][i]) blocked = 1'b1;
         end
         grant[i] = ready[i] && !blocked;
      end
   end
`else
   always_comb begin
      logic found;
      grant = '0;
      found = 1'b0;
      for (int i = 0; i < ENTRIES; i++) begin
         if (ready[i] && !found) begin
            grant[i] = 1'b1;
            found    = 1'b1;
         end
      end
   end
`endif

   assign grant_valid = |ready;

endmodule

// File: rtl/rs_int_sched.sv
// Integer reservation station: dispatch into the lowest free slot, CDB wakeup, one issue
// per cycle over valid/ready. Optional oldest-first select via RS_INT_AGE_SELECT_EN.
module rs_int_sched
   import rs_pkg::*;
#(
   parameter int ENTRIES = 4,
   // Entry storage uses the rs_pkg widths; these must stay equal to them.
   parameter int TAG_W   = RS_TAG_W,
   parameter int DATA_W  = RS_DATA_W,
   parameter int OP_W    = RS_OP_W,
   localparam int CNT_W  = $clog2(ENTRIES + 1),
   localparam int IDX_W  = $clog2(ENTRIES)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              flush,
   input  logic              disp_we,
   input  logic [OP_W-1:0]   disp_op,
   input  logic [TAG_W-1:0]  disp_dest,
   input  logic              disp_src1_rdy,
   input  logic              disp_src2_rdy,
   input  logic [TAG_W-1:0]  disp_src1_tag,
   input  logic [TAG_W-1:0]  disp_src2_tag,
   input  logic [DATA_W-1:0] disp_src1_val,
   input  logic [DATA_W-1:0] disp_src2_val,
   input  logic              cdb_valid,
   input  logic [TAG_W-1:0]  cdb_tag,
   input  logic [DATA_W-1:0] cdb_val,
   output logic              is_full,
   output logic [CNT_W-1:0]  count,
   output logic              issue_valid,
   input  logic              issue_ready,
   output logic [OP_W-1:0]   issue_op,
   output logic [TAG_W-1:0]  issue_dest,
   output logic [DATA_W-1:0] issue_src1,
   output logic [DATA_W-1:0] issue_src2
);

   rs_entry_t          ents_q [ENTRIES];
   rs_entry_t          ents_d [ENTRIES];
   logic [CNT_W-1:0]   count_q, count_d;
   logic [ENTRIES-1:0] ready_vec;
   logic [ENTRIES-1:0] sel_grant;
   logic               sel_valid;
   logic [ENTRIES-1:0] grant;
   logic [IDX_W-1:0]   disp_idx;
   logic               disp_ok;
   logic               issue_fire;

   assign count   = count_q;
   assign is_full = (count_q == CNT_W'(ENTRIES));
   assign disp_ok = disp_we && !is_full;

   // Lowest-index free slot; only meaningful when the station is not full.
   always_comb begin
      logic found;
      disp_idx = '0;
      found    = 1'b0;
      for (int i = 0; i < ENTRIES; i++) begin
         if (!ents_q[i].valid && !found) begin
            disp_idx = IDX_W'(i);
            found    = 1'b1;
         end
      end
   end

   always_comb begin
      for (int i = 0; i < ENTRIES; i++) begin
         ready_vec[i] = ents_q[i].valid && ents_q[i].src1.rdy && ents_q[i].src2.rdy;
      end
   end

`ifdef RS_INT_AGE_SELECT_EN
   logic [ENTRIES-1:0][ENTRIES-1:0] age_q, age_d;

   rs_select #(.ENTRIES(ENTRIES)) u_select (
      .ready       (ready_vec),
      .age         (age_q),
      .grant       (sel_grant),
      .grant_valid (sel_valid)
   );

   // Selection only moves to an older entry, so no stall lock is needed here.
   assign grant = sel_grant;

   always_comb begin
      age_d = age_q;
      if (flush) begin
         age_d = '0;
      end else begin
         for (int s = 0; s < ENTRIES; s++) begin
            if (issue_fire && grant[s]) begin
               for (int j = 0; j < ENTRIES; j++) begin
                  age_d[s][j] = 1'b0;
                  age_d[j][s] = 1'b0;
               end
            end
         end
         if (disp_ok) begin
            for (int j = 0; j < ENTRIES; j++) begin
               age_d[disp_idx][j] = 1'b0;
               age_d[j][disp_idx] = ents_q[j].valid && !(issue_fire && grant[j]);
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) age_q <= '0;
      else        age_q <= age_d;
   end
`else
   logic [ENTRIES-1:0] hold_q;

   rs_select #(.ENTRIES(ENTRIES)) u_select (
      .ready       (ready_vec),
      .grant       (sel_grant),
      .grant_valid (sel_valid)
   );

   // A stalled grant is locked so a lower-index entry waking up cannot displace it.
   assign grant = (|hold_q) ? hold_q : sel_grant;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                    hold_q <= '0;
      else if (flush || issue_ready) hold_q <= '0;
      else                           hold_q <= grant;
   end
`endif

   assign issue_valid = sel_valid && (|grant);
   assign issue_fire  = issue_valid && issue_ready;

   always_comb begin
      issue_op   = '0;
      issue_dest = '0;
      issue_src1 = '0;
      issue_src2 = '0;
      for (int i = 0; i < ENTRIES; i++) begin
         if (grant[i]) begin
            issue_op   = ents_q[i].op;
            issue_dest = ents_q[i].dest;
            issue_src1 = ents_q[i].src1.val;
            issue_src2 = ents_q[i].src2.val;
         end
      end
   end

   always_comb begin
      rs_src_t s1, s2;
      s1.rdy = disp_src1_rdy;
      s1.tag = disp_src1_tag;
      s1.val = disp_src1_val;
      s2.rdy = disp_src2_rdy;
      s2.tag = disp_src2_tag;
      s2.val = disp_src2_val;
      for (int i = 0; i < ENTRIES; i++) begin
         ents_d[i]      = ents_q[i];
         ents_d[i].src1 = snoop(ents_q[i].src1, cdb_valid, cdb_tag, cdb_val);
         ents_d[i].src2 = snoop(ents_q[i].src2, cdb_valid, cdb_tag, cdb_val);
         if (issue_fire && grant[i]) ents_d[i].valid = 1'b0;
      end
      if (disp_ok) begin
         ents_d[disp_idx].valid = 1'b1;
         ents_d[disp_idx].op    = disp_op;
         ents_d[disp_idx].dest  = disp_dest;
         ents_d[disp_idx].src1  = snoop(s1, cdb_valid, cdb_tag, cdb_val);
         ents_d[disp_idx].src2  = snoop(s2, cdb_valid, cdb_tag, cdb_val);
      end

      count_d = count_q;
      if (disp_ok && !issue_fire)      count_d = count_q + CNT_W'(1);
      else if (!disp_ok && issue_fire) count_d = count_q - CNT_W'(1);

      if (flush) begin
         for (int i = 0; i < ENTRIES; i++) ents_d[i].valid = 1'b0;
         count_d = '0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < ENTRIES; i++) ents_q[i] <= '0;
         count_q <= '0;
      end else begin
         for (int i = 0; i < ENTRIES; i++) ents_q[i] <= ents_d[i];
         count_q <= count_d;
      end
   end

endmodule

// File: tb/tb_rs_int_sched.sv
// Directed plus randomized bench for rs_int_sched against a slot-array reference model
// that tracks dispatch order with sequence numbers.
module tb_rs_int_sched;

   localparam int N = 4;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        flush;
   logic        disp_we;
   logic [4:0]  disp_op;
   logic [5:0]  disp_dest;
   logic        disp_src1_rdy, disp_src2_rdy;
   logic [5:0]  disp_src1_tag, disp_src2_tag;
   logic [31:0] disp_src1_val, disp_src2_val;
   logic        cdb_valid;
   logic [5:0]  cdb_tag;
   logic [31:0] cdb_val;
   logic        is_full;
   logic [2:0]  count;
   logic        issue_valid;
   logic        issue_ready;
   logic [4:0]  issue_op;
   logic [5:0]  issue_dest;
   logic [31:0] issue_src1, issue_src2;

   rs_int_sched #(.ENTRIES(N)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .flush         (flush),
      .disp_we       (disp_we),
      .disp_op       (disp_op),
      .disp_dest     (disp_dest),
      .disp_src1_rdy (disp_src1_rdy),
      .disp_src2_rdy (disp_src2_rdy),
      .disp_src1_tag (disp_src1_tag),
      .disp_src2_tag (disp_src2_tag),
      .disp_src1_val (disp_src1_val),
      .disp_src2_val (disp_src2_val),
      .cdb_valid     (cdb_valid),
      .cdb_tag       (cdb_tag),
      .cdb_val       (cdb_val),
      .is_full       (is_full),
      .count         (count),
      .issue_valid   (issue_valid),
      .issue_ready   (issue_ready),
      .issue_op      (issue_op),
      .issue_dest    (issue_dest),
      .issue_src1    (issue_src1),
      .issue_src2    (issue_src2)
   );

   always #5 clk = ~clk;

   // Reference model: one record per slot, age is a dispatch sequence number.
   bit          m_v [N];
   logic [4:0]  m_op [N];
   logic [5:0]  m_dest [N];
   bit          m_r1 [N], m_r2 [N];
   logic [5:0]  m_t1 [N], m_t2 [N];
   logic [31:0] m_s1 [N], m_s2 [N];
   int          m_age [N];
   int          m_seq;
   int          m_hold;
   int          vectors = 0;
   int          errors  = 0;

   function automatic int m_count();
      int c = 0;
      for (int i = 0; i < N; i++) if (m_v[i]) c++;
      return c;
   endfunction

   function automatic int m_pick();
      int best = -1;
      if (m_hold >= 0) return m_hold;
      for (int i = 0; i < N; i++) begin
         if (m_v[i] && m_r1[i] && m_r2[i]) begin
`ifdef RS_INT_AGE_SELECT_EN
            if (best < 0 || m_age[i] < m_age[best]) best = i;
`else
            if (best < 0) best = i;
`endif
         end
      end
      return best;
   endfunction

   task automatic m_clear();
      for (int i = 0; i < N; i++) m_v[i] = 0;
      m_hold = -1;
   endtask

   task automatic m_update();
      int p, c, k;
      bit fire;
      p = m_pick();
      c = m_count();
      fire = (p >= 0) && issue_ready;
      if (flush) begin
         m_clear();
         return;
      end
      k = -1;
      if (disp_we && c < N) begin
         for (int i = N - 1; i >= 0; i--) if (!m_v[i]) k = i;
      end
      for (int i = 0; i < N; i++) begin
         if (cdb_valid && !m_r1[i] && m_t1[i] == cdb_tag) begin m_r1[i] = 1; m_s1[i] = cdb_val; end
         if (cdb_valid && !m_r2[i] && m_t2[i] == cdb_tag) begin m_r2[i] = 1; m_s2[i] = cdb_val; end
      end
      if (fire) m_v[p] = 0;
      if (k >= 0) begin
         m_v[k] = 1; m_op[k] = disp_op; m_dest[k] = disp_dest;
         m_r1[k] = disp_src1_rdy; m_t1[k] = disp_src1_tag; m_s1[k] = disp_src1_val;
         m_r2[k] = disp_src2_rdy; m_t2[k] = disp_src2_tag; m_s2[k] = disp_src2_val;
         if (!m_r1[k] && cdb_valid && m_t1[k] == cdb_tag) begin m_r1[k] = 1; m_s1[k] = cdb_val; end
         if (!m_r2[k] && cdb_valid && m_t2[k] == cdb_tag) begin m_r2[k] = 1; m_s2[k] = cdb_val; end
         m_age[k] = m_seq;
         m_seq++;
      end
`ifndef RS_INT_AGE_SELECT_EN
      m_hold = (p >= 0 && !issue_ready) ? p : -1;
`endif
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic check_outputs();
      int c, p;
      c = m_count();
      p = m_pick();
      check("count", 32'(count), 32'(c));
      check("is_full", 32'(is_full), 32'(c == N));
      check("issue_valid", 32'(issue_valid), 32'(p >= 0));
      if (p >= 0) begin
         check("issue_op", 32'(issue_op), 32'(m_op[p]));
         check("issue_dest", 32'(issue_dest), 32'(m_dest[p]));
         check("issue_src1", issue_src1, m_s1[p]);
         check("issue_src2", issue_src2, m_s2[p]);
      end
   endtask

   task automatic tick();
      check_outputs();
      m_update();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      flush = 0; disp_we = 0; cdb_valid = 0;
   endtask

   task automatic set_disp(input logic [4:0] op, input logic [5:0] dest,
                           input logic r1, input logic [5:0] t1, input logic [31:0] v1,
                           input logic r2, input logic [5:0] t2, input logic [31:0] v2);
      disp_we = 1; disp_op = op; disp_dest = dest;
      disp_src1_rdy = r1; disp_src1_tag = t1; disp_src1_val = v1;
      disp_src2_rdy = r2; disp_src2_tag = t2; disp_src2_val = v2;
   endtask

   task automatic do_reset();
      rst_n = 0;
      m_clear();
      #2;
      check_outputs();
      @(negedge clk);
      rst_n = 1;
      #1;
   endtask

   initial begin
      int exp_sel;
      rst_n = 1; issue_ready = 1;
      idle();
      set_disp(0, 0, 0, 0, 0, 0, 0, 0);
      disp_we = 0;
      m_seq = 0;
      for (int i = 0; i < N; i++) begin
         m_v[i] = 0; m_r1[i] = 0; m_r2[i] = 0; m_t1[i] = 0; m_t2[i] = 0; m_age[i] = 0;
      end
      #3;
      do_reset();
      check("rst_count", 32'(count), 0);
      check("rst_issue_valid", 32'(issue_valid), 0);

      // basic issue
      set_disp(3, 5, 1, 0, 32'h11, 1, 0, 32'h22);
      tick();
      idle();
      check("basic_valid", 32'(issue_valid), 1);
      check("basic_dest", 32'(issue_dest), 5);
      check("basic_src1", issue_src1, 32'h11);
      check("basic_src2", issue_src2, 32'h22);
      check("basic_count1", 32'(count), 1);
      tick();
      check("basic_count0", 32'(count), 0);

      // fill with src1 waiting on tag 9
      issue_ready = 0;
      for (int i = 0; i < N; i++) begin
         set_disp(5'(i + 1), 6'(10 + i), 0, 9, 0, 1, 0, 32'(i));
         tick();
      end
      idle();
      check("fill_full", 32'(is_full), 1);
      check("fill_count", 32'(count), 4);
      check("fill_valid", 32'(issue_valid), 0);
      cdb_valid = 1; cdb_tag = 9; cdb_val = 32'hAB;
      tick();
      idle();
      check("wake_valid", 32'(issue_valid), 1);
      check("wake_src1", issue_src1, 32'hAB);

      // dispatch and issue together while full
      issue_ready = 1;
      set_disp(7, 20, 1, 0, 1, 1, 0, 2);
      tick();
      idle();
      check("full_disp_count", 32'(count), 3);
      check("full_disp_is_full", 32'(is_full), 0);
      for (int i = 0; i < 4; i++) tick();
      check("drain_count", 32'(count), 0);

      // dispatch-cycle bypass
      set_disp(2, 30, 1, 0, 32'h1, 0, 7, 0);
      cdb_valid = 1; cdb_tag = 7; cdb_val = 32'h55;
      tick();
      idle();
      check("bypass_valid", 32'(issue_valid), 1);
      check("bypass_src2", issue_src2, 32'h55);
      tick();

      // back-pressure then flush with dispatch
      issue_ready = 0;
      set_disp(4, 40, 1, 0, 32'h66, 1, 0, 32'h77);
      tick();
      set_disp(6, 41, 1, 0, 32'h1, 1, 0, 32'h2);
      for (int i = 0; i < 3; i++) begin
         check("hold_dest", 32'(issue_dest), 40);
         check("hold_src1", issue_src1, 32'h66);
         tick();
         idle();
      end
      flush = 1;
      set_disp(1, 42, 1, 0, 0, 1, 0, 0);
      tick();
      idle();
      check("flush_count", 32'(count), 0);
      check("flush_valid", 32'(issue_valid), 0);

      // select order: slot 2 dispatched before slot 0
      set_disp(1, 48, 0, 2, 0, 1, 0, 0);  tick();
      set_disp(1, 49, 0, 3, 0, 1, 0, 0);  tick();
      set_disp(1, 52, 0, 4, 0, 1, 0, 0);  tick();
      idle();
      cdb_valid = 1; cdb_tag = 2; cdb_val = 32'h5;
      tick();
      idle();
      issue_ready = 1;
      tick();
      issue_ready = 0;
      set_disp(1, 50, 0, 4, 0, 1, 0, 0); tick();
      idle();
      cdb_valid = 1; cdb_tag = 4; cdb_val = 32'h9;
      tick();
      idle();
`ifdef RS_INT_AGE_SELECT_EN
      exp_sel = 52;
`else
      exp_sel = 50;
`endif
      check("select_order", 32'(issue_dest), 32'(exp_sel));
      tick();

      // asynchronous reset mid-operation, then dispatch on the first edge
      #2;
      do_reset();
      set_disp(9, 60, 1, 0, 3, 1, 0, 4);
      tick();
      idle();
      check("post_rst_count", 32'(count), 1);

      // randomized traffic
      for (int n = 0; n < 400; n++) begin
         idle();
         if (m_count() < N && $urandom_range(0, 1) == 1) begin
            set_disp(5'($urandom_range(0, 31)), 6'($urandom_range(0, 63)),
                     1'($urandom_range(0, 1)), 6'($urandom_range(1, 6)), $urandom,
                     1'($urandom_range(0, 1)), 6'($urandom_range(1, 6)), $urandom);
         end
         cdb_valid   = ($urandom_range(0, 2) != 0);
         cdb_tag     = 6'($urandom_range(1, 6));
         cdb_val     = $urandom;
         issue_ready = ($urandom_range(0, 3) != 0);
         flush       = ($urandom_range(0, 63) == 0);
         tick();
      end
      idle();
      issue_ready = 1;
      tick();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule
